control_fsm: RTL and testbench
==============================

CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter HALT_OPCODE, default 6'b111111, opcode that halts the core when HALT_EN is defined.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 opcode  in  6  instruction[31:26], valid from DECODE onward (IR output).
REQ-005 mem_ready  in  1  memory completes the access this cycle.
REQ-006 alu_op  out  3  registered ALU operation class: 000 R-type (funct), 001 pass data1, 011 pass data2, 100 branch-equal, 101 branch-not-equal.
REQ-007 pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write  out  1 each  datapath strobes.
REQ-008 pc_src  out  2  00 PC+4, 01 branch target, 10 jump target.
REQ-009 reg_dst, mem_to_reg  out  1 each  1 = rd / memory data; 0 = rt / ALU result.
REQ-010 illegal_op  out  1  one-cycle pulse on an undecodable opcode.
REQ-011 halted  out  1  high while in HALT.
REQ-012 state  out  4  current state encoding, for debug.

Function
REQ-013 States: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, JUMP=10, ILLEGAL=11, HALT=12; other encodings SHALL go to FETCH next cycle.
REQ-014 FETCH: mem_read=1, ir_write=pc_write=mem_ready, pc_src=00; stays until mem_ready=1, then DECODE.
REQ-015 DECODE (1 cycle) SHALL dispatch: 000000->EXEC_R, 001111 (ldi)->EXEC_I, 100011/101011 (lw/sw)->ADDR, 000100/000101->BRANCH, 000010->JUMP, others->ILLEGAL.
REQ-016 alu_op SHALL load on DECODE exit (R 000, ldi 011, lw/sw 001, beq 100, bne 101, else 000) and hold until next DECODE exit.
REQ-017 EXEC_R and EXEC_I: strobes low, 1 cycle, -> WB_ALU; WB_ALU: reg_write=1, reg_dst=1 only for R-type, mem_to_reg=0, -> FETCH.
REQ-018 ADDR: 1 cycle, -> MEM_RD (lw) or MEM_WR (sw).
REQ-019 MEM_RD: mem_read=1 until mem_ready, then WB_MEM; WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0, -> FETCH.
REQ-020 MEM_WR: mem_write=1 until mem_ready, then FETCH.
REQ-021 BRANCH: pc_write_cond=1, pc_src=01, 1 cycle, -> FETCH; JUMP: pc_write=1, pc_src=10, 1 cycle, -> FETCH.
REQ-022 ILLEGAL: illegal_op=1 exactly one cycle, no other strobe, -> FETCH.
REQ-023 Latency with mem_ready always high: R/ldi 4 cycles, lw 5, sw 4, branch/jump 3, illegal 3.
REQ-024 Strobes are Moore outputs of state; at most one of mem_read/mem_write high in any cycle.
REQ-025 mem_ready outside FETCH/MEM_RD/MEM_WR SHALL be ignored.

Reset
REQ-026 rst_n low SHALL immediately force state=FETCH, alu_op=000, all strobes, pc_src, illegal_op, halted to 0, including mid-access.
REQ-027 First FETCH strobes SHALL appear the first clk edge after rst_n deasserts, never during reset.

Configuration
REQ-028 Macro CONTROL_FSM_HALT_EN defined: DECODE with opcode==HALT_OPCODE -> HALT; HALT holds halted=1, all strobes 0, until reset.
REQ-029 Macro undefined: HALT state absent, HALT_OPCODE decodes as ILLEGAL, halted tied 0.

Verification
REQ-030 Reset, opcode=000000, mem_ready=1 -> states 0,1,2,7,0; reg_write=1 only in cycle 4, reg_dst=1, alu_op=000.
REQ-031 opcode=100011, mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles with mem_read=1, then WB_MEM with mem_to_reg=1.
REQ-032 opcode=000101 -> alu_op=101, BRANCH with pc_write_cond=1, pc_src=01, back to FETCH.
REQ-033 opcode=010101 -> illegal_op pulse exactly 1 cycle in state 11, then FETCH.
REQ-034 rst_n low mid MEM_WR -> mem_write drops asynchronously, state=0, alu_op=000.
REQ-035 opcode=111111 -> with CONTROL_FSM_HALT_EN: halted=1 indefinitely; without: illegal_op pulse.

Source files
------------

// File: rtl/control_fsm_if.sv
// ============================================================================
//  Module      : control_fsm_if
//  Description : Datapath/controller bundle for control_fsm: decoded-opcode
//                and memory-ready inputs, datapath strobes and debug state.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface control_fsm_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [2:0] alu_op;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] pc_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;
    logic       halted;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output alu_op, pc_write, pc_write_cond, ir_write, mem_read, mem_write,
               reg_write, pc_src, reg_dst, mem_to_reg, illegal_op, halted, state
    );

    modport slave (
        output opcode, mem_ready,
        input  alu_op, pc_write, pc_write_cond, ir_write, mem_read, mem_write,
               reg_write, pc_src, reg_dst, mem_to_reg, illegal_op, halted, state
    );
endinterface

`default_nettype wire

// File: rtl/control_fsm.sv
// ============================================================================
//  Module      : control_fsm
//  Description : Multi-cycle processor control FSM. Define CONTROL_FSM_HALT_EN
//                to enable the HALT state reached via HALT_OPCODE.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_fsm #(
    parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    control_fsm_if.master  bus
);
    localparam logic [3:0] c_fetch   = 4'd0;
    localparam logic [3:0] c_decode  = 4'd1;
    localparam logic [3:0] c_exec_r  = 4'd2;
    localparam logic [3:0] c_exec_i  = 4'd3;
    localparam logic [3:0] c_addr    = 4'd4;
    localparam logic [3:0] c_mem_rd  = 4'd5;
    localparam logic [3:0] c_mem_wr  = 4'd6;
    localparam logic [3:0] c_wb_alu  = 4'd7;
    localparam logic [3:0] c_wb_mem  = 4'd8;
    localparam logic [3:0] c_branch  = 4'd9;
    localparam logic [3:0] c_jump    = 4'd10;
    localparam logic [3:0] c_illegal = 4'd11;
`ifdef CONTROL_FSM_HALT_EN
    localparam logic [3:0] c_halt    = 4'd12;
`endif

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_ldi   = 6'b001111;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_j     = 6'b000010;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [3:0] w_dispatch;
    logic [2:0] r_alu_op;
    logic [2:0] w_alu_dec;
    // Cleared by reset so no strobe is visible until the first clock edge after release
    logic       r_run;

    always_comb begin
        w_dispatch = c_illegal;
        w_alu_dec  = 3'b000;
        if (bus.opcode == HALT_OPCODE) begin
`ifdef CONTROL_FSM_HALT_EN
            w_dispatch = c_halt;
`else
            w_dispatch = c_illegal;
`endif
        end else begin
            case (bus.opcode)
                c_op_rtype: begin w_dispatch = c_exec_r; w_alu_dec = 3'b000; end
                c_op_ldi:   begin w_dispatch = c_exec_i; w_alu_dec = 3'b011; end
                c_op_lw,
                c_op_sw:    begin w_dispatch = c_addr;   w_alu_dec = 3'b001; end
                c_op_beq:   begin w_dispatch = c_branch; w_alu_dec = 3'b100; end
                c_op_bne:   begin w_dispatch = c_branch; w_alu_dec = 3'b101; end
                c_op_j:     begin w_dispatch = c_jump;   w_alu_dec = 3'b000; end
                default:    begin w_dispatch = c_illegal; w_alu_dec = 3'b000; end
            endcase
        end
    end

    always_comb begin
        w_next = c_fetch;
        case (r_state)
            c_fetch:   w_next = bus.mem_ready ? c_decode : c_fetch;
            c_decode:  w_next = w_dispatch;
            c_exec_r:  w_next = c_wb_alu;
            c_exec_i:  w_next = c_wb_alu;
            c_addr:    w_next = (bus.opcode == c_op_lw) ? c_mem_rd : c_mem_wr;
            c_mem_rd:  w_next = bus.mem_ready ? c_wb_mem : c_mem_rd;
            c_mem_wr:  w_next = bus.mem_ready ? c_fetch : c_mem_wr;
`ifdef CONTROL_FSM_HALT_EN
            c_halt:    w_next = c_halt;
`endif
            default:   w_next = c_fetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_fetch;
            r_alu_op <= 3'b000;
            r_run    <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (r_run) begin
                r_state <= w_next;
                if (r_state == c_decode) begin
                    r_alu_op <= w_alu_dec;
                end
            end
        end
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.reg_write     = 1'b0;
        bus.pc_src        = 2'b00;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.illegal_op    = 1'b0;
        bus.halted        = 1'b0;
        if (r_run) begin
            case (r_state)
                c_fetch: begin
                    bus.mem_read = 1'b1;
                    bus.ir_write = bus.mem_ready;
                    bus.pc_write = bus.mem_ready;
                end
                c_mem_rd:  bus.mem_read = 1'b1;
                c_mem_wr:  bus.mem_write = 1'b1;
                c_wb_alu: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = (bus.opcode == c_op_rtype);
                end
                c_wb_mem: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
                c_branch: begin
                    bus.pc_write_cond = 1'b1;
                    bus.pc_src        = 2'b01;
                end
                c_jump: begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = 2'b10;
                end
                c_illegal: bus.illegal_op = 1'b1;
`ifdef CONTROL_FSM_HALT_EN
                c_halt:    bus.halted = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign bus.state  = r_state;
    assign bus.alu_op = r_alu_op;
endmodule

`default_nettype wire

// File: tb/tb_control_fsm.sv
// ============================================================================
//  Module      : tb_control_fsm
//  Description : Self-checking bench for control_fsm (vector table, directed
//                corner cases and random instruction streams).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_fsm;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    control_fsm_if bus();
    control_fsm #(.HALT_OPCODE(6'b111111)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] alu;
        logic       pcw, pcwc, irw, mrd, mwr, rw;
        logic [1:0] psrc;
        logic       rdst, m2r, ill, hlt;
    } obs_t;

    typedef struct { int st; logic rdy; } step_t;
    typedef struct { logic [5:0] op; logic [2:0] alu; int lat; int third; } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [2:0]  prev_alu = 3'b000;
    step_t       path[$];
    vec_t        vecs[$];
    logic [5:0]  ops[8] = '{6'h00, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h15};

    function automatic obs_t observe();
        obs_t o;
        o.st = bus.state;  o.alu = bus.alu_op;
        o.pcw = bus.pc_write; o.pcwc = bus.pc_write_cond; o.irw = bus.ir_write;
        o.mrd = bus.mem_read; o.mwr = bus.mem_write; o.rw = bus.reg_write;
        o.psrc = bus.pc_src; o.rdst = bus.reg_dst; o.m2r = bus.mem_to_reg;
        o.ill = bus.illegal_op; o.hlt = bus.halted;
        return o;
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] op);
        case (op)
            6'h0f:        return 3'b011;
            6'h23, 6'h2b: return 3'b001;
            6'h04:        return 3'b100;
            6'h05:        return 3'b101;
            default:      return 3'b000;
        endcase
    endfunction

    // Expected outputs of each named phase, straight from the strobe table
    function automatic obs_t expect_for(input int st, input logic [5:0] op,
                                        input logic rdy, input logic [2:0] alu);
        obs_t o = '0;
        o.st  = 4'(st);
        o.alu = alu;
        case (st)
            0:  begin o.mrd = 1'b1; o.irw = rdy; o.pcw = rdy; end
            5:  o.mrd = 1'b1;
            6:  o.mwr = 1'b1;
            7:  begin o.rw = 1'b1; o.rdst = (op == 6'h00); end
            8:  begin o.rw = 1'b1; o.m2r = 1'b1; end
            9:  begin o.pcwc = 1'b1; o.psrc = 2'b01; end
            10: begin o.pcw = 1'b1; o.psrc = 2'b10; end
            11: o.ill = 1'b1;
            12: o.hlt = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t exp);
        obs_t got = observe();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (state %0d vs %0d)", name, got, exp,
                     got.st, exp.st);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic push(input int st, input int n, input int last_rdy);
        for (int k = 0; k < n; k++) begin
            step_t s;
            s.st  = st;
            s.rdy = (last_rdy < 0) ? 1'($urandom % 2) : ((k == n - 1) ? 1'(last_rdy) : 1'b0);
            path.push_back(s);
        end
    endtask

    // Instruction-level reference: phase list for one instruction
    task automatic build_path(input logic [5:0] op, input int wf, input int wm);
        path.delete();
        push(0, wf + 1, 1);
        push(1, 1, -1);
`ifdef CONTROL_FSM_HALT_EN
        if (op == 6'h3f) begin push(12, 4, -1); return; end
`endif
        case (op)
            6'h00: begin push(2, 1, -1); push(7, 1, -1); end
            6'h0f: begin push(3, 1, -1); push(7, 1, -1); end
            6'h23: begin push(4, 1, -1); push(5, wm + 1, 1); push(8, 1, -1); end
            6'h2b: begin push(4, 1, -1); push(6, wm + 1, 1); end
            6'h04, 6'h05: push(9, 1, -1);
            6'h02: push(10, 1, -1);
            default: push(11, 1, -1);
        endcase
    endtask

    task automatic run_path(input string name, input logic [5:0] op, input int wf, input int wm);
        logic [2:0] new_alu = alu_of(op);
        build_path(op, wf, wm);
        bus.opcode = op;
        foreach (path[i]) begin
            @(negedge clk);
            bus.mem_ready = path[i].rdy;
            #1;
            check_obs(name, expect_for(path[i].st, op, path[i].rdy,
                                       (i <= wf + 1) ? prev_alu : new_alu));
        end
        prev_alu = new_alu;
    endtask

    task automatic add_vec(input logic [5:0] op, input logic [2:0] alu, input int lat, input int third);
        vec_t v;
        v.op = op; v.alu = alu; v.lat = lat; v.third = third;
        vecs.push_back(v);
    endtask

    initial begin
        obs_t zero = '0;
        int   cyc, third;

        add_vec(6'h00, 3'b000, 4, 2);
        add_vec(6'h0f, 3'b011, 4, 3);
        add_vec(6'h23, 3'b001, 5, 4);
        add_vec(6'h2b, 3'b001, 4, 4);
        add_vec(6'h04, 3'b100, 3, 9);
        add_vec(6'h05, 3'b101, 3, 9);
        add_vec(6'h02, 3'b000, 3, 10);
        add_vec(6'h15, 3'b000, 3, 11);
`ifndef CONTROL_FSM_HALT_EN
        add_vec(6'h3f, 3'b000, 3, 11);
`endif

        rst_n = 1'b0; bus.opcode = 6'h00; bus.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_obs("reset_state", zero);
        rst_n = 1'b1;
        #1 check_obs("no_strobe_before_edge", zero);

        // R-type walk 0,1,2,7 then lw with three wait cycles in MEM_RD
        run_path("rtype_seq", 6'h00, 0, 0);
        run_path("lw_wait", 6'h23, 0, 3);
        run_path("bne_seq", 6'h05, 0, 0);
        run_path("illegal_seq", 6'h15, 0, 0);

        foreach (vecs[i]) begin
            bus.opcode = vecs[i].op; bus.mem_ready = 1'b0;
            @(negedge clk); #1;
            check_int("vec_start_fetch", int'(bus.state), 0);
            bus.mem_ready = 1'b1;
            cyc = 1; third = -1;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk); #1;
                cyc++;
                if (cyc == 3) third = int'(bus.state);
                if (bus.state == 4'd0) break;
            end
            check_int("vec_latency", cyc - 1, vecs[i].lat);
            check_int("vec_exec_state", third, vecs[i].third);
            check_int("vec_alu_op", int'(bus.alu_op), int'(vecs[i].alu));
            bus.mem_ready = 1'b0;
            prev_alu = vecs[i].alu;
        end

        // Asynchronous reset while a store is waiting on memory
        bus.opcode = 6'h2b;
        @(negedge clk); bus.mem_ready = 1'b1;
        @(negedge clk); bus.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check_obs("mem_wr_wait", expect_for(6, 6'h2b, 1'b0, 3'b001));
        #1 rst_n = 1'b0;
        #1 check_obs("async_reset_mid_wr", zero);
        @(negedge clk); rst_n = 1'b1;
        prev_alu = 3'b000;

        for (int n = 0; n < 200; n++) begin
            logic [5:0] op;
            int r = int'($urandom % 10);
            op = (r < 8) ? ops[r] : 6'($urandom);
`ifdef CONTROL_FSM_HALT_EN
            if (op == 6'h3f) op = 6'h15;
`endif
            run_path("random", op, int'($urandom % 4), int'($urandom % 4));
        end

`ifdef CONTROL_FSM_HALT_EN
        run_path("halt_seq", 6'h3f, 0, 0);
`else
        run_path("halt_op_illegal", 6'h3f, 1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
